// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_if
// Bundle of the reservation-station result ports and the common data bus
// (CDB) broadcast ports of cdb_arbiter.
//
// Signals (source i occupies bits [i*W +: W] of each packed per-source field):
//   in_valid   [N_SRC]          result offered by source i
//   in_tag     [N_SRC*TAG_W]    result tag
//   in_val     [N_SRC*DATA_W]   result value
//   in_icc     [N_SRC*4]        result flags {c,v,z,n}
//   in_icc_we  [N_SRC]          result updates ICC
//   out_ready  [N_SRC]          slot i accepts this cycle
//   out_CDB_broadcast           one-cycle broadcast strobe
//   out_CDB_tag/val/icc/icc_we  broadcast payload
//   out_CDB_src                 index of the granted source
//   out_drop                    one-cycle pulse: an INVALID_TAG result was discarded
//
// Modports:
//   master : the result producers (drive in_*, observe out_*)
//   slave  : the arbiter itself  (observe in_*, drive out_*)
// -----------------------------------------------------------------------------
interface cdb_arbiter_if #(
    parameter int N_SRC  = 4,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32
);
    localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0]        in_valid;
    logic [N_SRC*TAG_W-1:0]  in_tag;
    logic [N_SRC*DATA_W-1:0] in_val;
    logic [N_SRC*4-1:0]      in_icc;
    logic [N_SRC-1:0]        in_icc_we;
    logic [N_SRC-1:0]        out_ready;
    logic                    out_CDB_broadcast;
    logic [TAG_W-1:0]        out_CDB_tag;
    logic [DATA_W-1:0]       out_CDB_val;
    logic [3:0]              out_CDB_icc;
    logic                    out_CDB_icc_we;
    logic [SRC_W-1:0]        out_CDB_src;
    logic                    out_drop;

    modport master (
        output in_valid, in_tag, in_val, in_icc, in_icc_we,
        input  out_ready, out_CDB_broadcast, out_CDB_tag, out_CDB_val,
               out_CDB_icc, out_CDB_icc_we, out_CDB_src, out_drop
    );

    modport slave (
        input  in_valid, in_tag, in_val, in_icc, in_icc_we,
        output out_ready, out_CDB_broadcast, out_CDB_tag, out_CDB_val,
               out_CDB_icc, out_CDB_icc_we, out_CDB_src, out_drop
    );
endinterface

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Buffers one finished result per reservation station and serializes them onto
// the single common data bus, one broadcast per cycle.
//
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous reset, active high; flushes every buffered result
//   bus  : cdb_arbiter_if.slave (per-source results in, CDB broadcast out)
//
// Build option:
//   CDB_FIXED_PRIO_EN  defined   -> fixed priority, lowest source index wins,
//                                   no round-robin pointer, no fairness
//                      undefined -> round-robin starting after the last winner
//
// Handshake (per source i): a result transfers on a rising edge when
// in_valid[i] && out_ready[i]. out_ready[i] = !full[i] | grant[i], so a slot
// that is broadcast this cycle can be refilled on the same edge. The source
// must hold tag/val/icc stable while in_valid is high and out_ready is low.
// A transfer whose tag equals INVALID_TAG completes but is not stored; the
// slot ends empty and out_drop pulses the following cycle.
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int               N_SRC       = 4,
    parameter int               TAG_W       = 5,
    parameter int               DATA_W      = 32,
    parameter logic [TAG_W-1:0] INVALID_TAG = {TAG_W{1'b1}}
) (
    input  logic         clk,
    input  logic         rst,
    cdb_arbiter_if.slave bus
);
    localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    // Flattened view of the per-source slots.
    logic [N_SRC-1:0]        w_full;
    logic [N_SRC*TAG_W-1:0]  w_slot_tag;
    logic [N_SRC*DATA_W-1:0] w_slot_val;
    logic [N_SRC*4-1:0]      w_slot_icc;
    logic [N_SRC-1:0]        w_slot_icc_we;
    logic [N_SRC-1:0]        w_ready;
    logic [N_SRC-1:0]        w_cap_inv;

    // Arbitration result.
    logic [N_SRC-1:0]        w_grant;
    logic [SRC_W-1:0]        w_gnt_idx;
    logic [SRC_W-1:0]        w_cand;
    logic                    w_gnt_any;

    // CDB output registers.
    logic                    r_bcast;
    logic [TAG_W-1:0]        r_cdb_tag;
    logic [DATA_W-1:0]       r_cdb_val;
    logic [3:0]              r_cdb_icc;
    logic                    r_cdb_icc_we;
    logic [SRC_W-1:0]        r_cdb_src;
    logic                    r_drop;

    // -------------------------------------------------------------------------
    // Per-source result slots
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_slot
        logic              r_full;
        logic [TAG_W-1:0]  r_tag;
        logic [DATA_W-1:0] r_val;
        logic [3:0]        r_icc;
        logic              r_icc_we;
        logic              w_cap;
        logic              w_inv;

        assign w_ready[gi] = !r_full | w_grant[gi];
        assign w_cap       = bus.in_valid[gi] & w_ready[gi];
        assign w_inv       = (bus.in_tag[gi*TAG_W +: TAG_W] == INVALID_TAG);
        assign w_cap_inv[gi] = w_cap & w_inv;

        // A capture wins over the clear from a grant on the same edge, so a
        // refill keeps the new result. An invalid-tag capture leaves it empty.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_full   <= 1'b0;
                r_tag    <= INVALID_TAG;
                r_val    <= '0;
                r_icc    <= '0;
                r_icc_we <= 1'b0;
            end else if (w_cap) begin
                r_full <= !w_inv;
                if (!w_inv) begin
                    r_tag    <= bus.in_tag[gi*TAG_W +: TAG_W];
                    r_val    <= bus.in_val[gi*DATA_W +: DATA_W];
                    r_icc    <= bus.in_icc[gi*4 +: 4];
                    r_icc_we <= bus.in_icc_we[gi];
                end
            end else if (w_grant[gi]) begin
                r_full <= 1'b0;
            end
        end

        assign w_full[gi]                       = r_full;
        assign w_slot_tag[gi*TAG_W +: TAG_W]    = r_tag;
        assign w_slot_val[gi*DATA_W +: DATA_W]  = r_val;
        assign w_slot_icc[gi*4 +: 4]            = r_icc;
        assign w_slot_icc_we[gi]                = r_icc_we;
    end

    // -------------------------------------------------------------------------
    // Arbitration: depends only on slot occupancy (and the pointer), never on
    // in_valid, so there is no combinational path from in_valid to the CDB.
    // -------------------------------------------------------------------------
`ifdef CDB_FIXED_PRIO_EN
    // Scan from the highest index down so the lowest full index is kept.
    always_comb begin
        w_cand    = '0;
        w_gnt_idx = '0;
        w_gnt_any = 1'b0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            w_cand = SRC_W'(k);
            if (w_full[w_cand]) begin
                w_gnt_idx = w_cand;
                w_gnt_any = 1'b1;
            end
        end
    end
`else
    logic [SRC_W-1:0] r_ptr;

    // Candidates are ptr+1, ptr+2, ... modulo N_SRC. Scanning the offsets in
    // reverse lets the nearest full slot overwrite any farther one.
    always_comb begin
        w_cand    = '0;
        w_gnt_idx = '0;
        w_gnt_any = 1'b0;
        for (int k = N_SRC; k >= 1; k--) begin
            w_cand = SRC_W'((int'(r_ptr) + k) % N_SRC);
            if (w_full[w_cand]) begin
                w_gnt_idx = w_cand;
                w_gnt_any = 1'b1;
            end
        end
    end

    // Reset value N_SRC-1 makes source 0 the first candidate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= SRC_W'(N_SRC - 1);
        end else if (w_gnt_any) begin
            r_ptr <= w_gnt_idx;
        end
    end
`endif

    always_comb begin
        w_grant = '0;
        if (w_gnt_any) begin
            w_grant[w_gnt_idx] = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // CDB output registers: payload holds its last value when idle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcast      <= 1'b0;
            r_cdb_tag    <= INVALID_TAG;
            r_cdb_val    <= '0;
            r_cdb_icc    <= '0;
            r_cdb_icc_we <= 1'b0;
            r_cdb_src    <= '0;
            r_drop       <= 1'b0;
        end else begin
            r_bcast <= w_gnt_any;
            r_drop  <= |w_cap_inv;
            if (w_gnt_any) begin
                r_cdb_tag    <= w_slot_tag[w_gnt_idx*TAG_W +: TAG_W];
                r_cdb_val    <= w_slot_val[w_gnt_idx*DATA_W +: DATA_W];
                r_cdb_icc    <= w_slot_icc[w_gnt_idx*4 +: 4];
                r_cdb_icc_we <= w_slot_icc_we[w_gnt_idx];
                r_cdb_src    <= w_gnt_idx;
            end
        end
    end

    assign bus.out_ready         = w_ready;
    assign bus.out_CDB_broadcast = r_bcast;
    assign bus.out_CDB_tag       = r_cdb_tag;
    assign bus.out_CDB_val       = r_cdb_val;
    assign bus.out_CDB_icc       = r_cdb_icc;
    assign bus.out_CDB_icc_we    = r_cdb_icc_we;
    assign bus.out_CDB_src       = r_cdb_src;
    assign bus.out_drop          = r_drop;
endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Self-checking bench for cdb_arbiter. Inputs change 1 time unit after each
// rising edge; outputs are sampled on the falling edge. Every broadcast is
// popped from exp_q and compared field by field.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;
  localparam int N_SRC  = 4;
  localparam int TAG_W  = 5;
  localparam int DATA_W = 32;
  localparam int SRC_W  = 2;
  localparam int EXP_W  = SRC_W + 1 + 4 + DATA_W + TAG_W;

  typedef struct {
    int          src;
    logic [4:0]  tag;
    logic [31:0] val;
    logic [3:0]  icc;
    logic        we;
    logic        exp_drop;
  } vec_t;

  logic clk;
  logic rst;

  cdb_arbiter_if #(.N_SRC(N_SRC), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

  cdb_arbiter #(.N_SRC(N_SRC), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int bcast_cnt = 0;
  int drop_cnt = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] val_of(input logic [4:0] tag);
    return 32'h5A5A_0000 | 32'(tag);
  endfunction

  function automatic logic [EXP_W-1:0] pack_exp(input int src, input logic we,
      input logic [3:0] icc, input logic [31:0] val, input logic [4:0] tag);
    return {SRC_W'(src), we, icc, val, tag};
  endfunction

  task automatic push_exp(input int src, input logic [4:0] tag);
    exp_q.push_back(pack_exp(src, tag[0], tag[3:0], val_of(tag), tag));
  endtask

  // Monitor: every broadcast must match the head of the expected queue.
  always @(negedge clk) begin
    logic [EXP_W-1:0] got;
    logic [EXP_W-1:0] e;
    if (rst === 1'b0) begin
      if (bus.out_drop === 1'b1) drop_cnt++;
      if (bus.out_CDB_broadcast === 1'b1) begin
        bcast_cnt++;
        got = {bus.out_CDB_src, bus.out_CDB_icc_we, bus.out_CDB_icc,
               bus.out_CDB_val, bus.out_CDB_tag};
        if (exp_q.size() == 0) begin
          check("bcast_unexpected", 64'(got), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("bcast_payload", 64'(got), 64'(e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_raw(input int i, input logic [4:0] tag, input logic [31:0] val,
                         input logic [3:0] icc, input logic we);
    bus.in_tag[i*TAG_W +: TAG_W]    = tag;
    bus.in_val[i*DATA_W +: DATA_W]  = val;
    bus.in_icc[i*4 +: 4]            = icc;
    bus.in_icc_we[i]                = we;
  endtask

  task automatic set_tag(input int i, input logic [4:0] tag);
    set_raw(i, tag, val_of(tag), tag[3:0], tag[0]);
  endtask

  task automatic do_reset;
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    bus.in_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_bcast"}, 64'(bus.out_CDB_broadcast), 64'(0));
    check({pfx, "_tag"},   64'(bus.out_CDB_tag),       64'(5'h1F));
    check({pfx, "_val"},   64'(bus.out_CDB_val),       64'(0));
    check({pfx, "_icc"},   64'(bus.out_CDB_icc),       64'(0));
    check({pfx, "_we"},    64'(bus.out_CDB_icc_we),    64'(0));
    check({pfx, "_src"},   64'(bus.out_CDB_src),       64'(0));
    check({pfx, "_drop"},  64'(bus.out_drop),          64'(0));
    check({pfx, "_ready"}, 64'(bus.out_ready),         64'(4'hF));
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[6];

  initial begin
    int ia;
    int ib;
    int c;
    int waited;
    int b0;
    logic r1;
    logic r3;
    logic r0;
    logic [1:0] exp_rdy;
    logic [4:0] last_tag;

    vecs[0] = '{src: 0, tag: 5'd0,  val: 32'h0000_0000, icc: 4'b0000, we: 1'b0, exp_drop: 1'b0};
    vecs[1] = '{src: 1, tag: 5'd30, val: 32'hFFFF_FFFF, icc: 4'b1111, we: 1'b1, exp_drop: 1'b0};
    vecs[2] = '{src: 2, tag: 5'd31, val: 32'hDEAD_BEEF, icc: 4'b1010, we: 1'b1, exp_drop: 1'b1};
    vecs[3] = '{src: 3, tag: 5'd17, val: 32'h1234_5678, icc: 4'b0101, we: 1'b0, exp_drop: 1'b0};
    vecs[4] = '{src: 0, tag: 5'd31, val: 32'h0000_0000, icc: 4'b0000, we: 1'b0, exp_drop: 1'b1};
    vecs[5] = '{src: 3, tag: 5'd1,  val: 32'h8000_0001, icc: 4'b1000, we: 1'b1, exp_drop: 1'b0};

    rst = 1'b0;
    bus.in_valid  = '0;
    bus.in_tag    = '0;
    bus.in_val    = '0;
    bus.in_icc    = '0;
    bus.in_icc_we = '0;
    #1 rst = 1'b1;

    // ---- reset state ----
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1 rst = 1'b0;

    // ---- single result, latency ----
    set_raw(0, 5'd3, 32'h0000_0010, 4'b0001, 1'b1);
    bus.in_valid[0] = 1'b1;
    exp_q.push_back(pack_exp(0, 1'b1, 4'b0001, 32'h0000_0010, 5'd3));
    tick;
    bus.in_valid = '0;
    @(negedge clk);
    check("t1_lat0", 64'(bus.out_CDB_broadcast), 64'(0));
    @(negedge clk);
    check("t1_bcast", 64'(bus.out_CDB_broadcast), 64'(1));
    @(negedge clk);
    check("t1_once", 64'(bus.out_CDB_broadcast), 64'(0));
    tick;

    // ---- all sources on one edge ----
    do_reset;
    for (int i = 0; i < N_SRC; i++) begin
      set_tag(i, 5'(i));
      bus.in_valid[i] = 1'b1;
      push_exp(i, 5'(i));
    end
    tick;
    bus.in_valid = '0;
    b0 = bcast_cnt;
    @(negedge clk);
    check("t2_lat0", 64'(bus.out_CDB_broadcast), 64'(0));
    for (int i = 0; i < N_SRC; i++) begin
      @(negedge clk);
      check("t2_consec", 64'(bus.out_CDB_broadcast), 64'(1));
    end
    @(negedge clk);
    check("t2_idle", 64'(bus.out_CDB_broadcast), 64'(0));
    check("t2_count", 64'(bcast_cnt - b0), 64'(4));
    tick;

    // ---- table-driven single offers, incl. INVALID_TAG and extremes ----
    last_tag = 5'd0;
    for (int v = 0; v < 6; v++) begin
      b0 = drop_cnt;
      set_raw(vecs[v].src, vecs[v].tag, vecs[v].val, vecs[v].icc, vecs[v].we);
      bus.in_valid[vecs[v].src] = 1'b1;
      if (!vecs[v].exp_drop)
        exp_q.push_back(pack_exp(vecs[v].src, vecs[v].we, vecs[v].icc, vecs[v].val, vecs[v].tag));
      @(negedge clk);
      check("vec_ready", 64'(bus.out_ready[vecs[v].src]), 64'(1));
      tick;
      bus.in_valid = '0;
      @(negedge clk);
      check("vec_drop", 64'(bus.out_drop), 64'(vecs[v].exp_drop));
      check("vec_lat", 64'(bus.out_CDB_broadcast), 64'(0));
      @(negedge clk);
      check("vec_drop_once", 64'(bus.out_drop), 64'(0));
      check("vec_bcast", 64'(bus.out_CDB_broadcast), 64'(!vecs[v].exp_drop));
      if (vecs[v].exp_drop)
        check("vec_retain_tag", 64'(bus.out_CDB_tag), 64'(last_tag));
      else
        last_tag = vecs[v].tag;
      check("vec_drop_cnt", 64'(drop_cnt - b0), 64'(vecs[v].exp_drop));
      tick;
      tick;
    end

    // ---- sources 1 and 3 continuously valid, pointer at 1 ----
    do_reset;
    set_tag(1, 5'd9);
    bus.in_valid[1] = 1'b1;
    push_exp(1, 5'd9);
    tick;
    bus.in_valid = '0;
    repeat (3) tick;
`ifdef CDB_FIXED_PRIO_EN
    for (int k = 0; k < 7; k++) push_exp(1, 5'(8 + k));
    push_exp(3, 5'd16);
`else
    for (int k = 0; k < 4; k++) begin
      push_exp(3, 5'(16 + k));
      push_exp(1, 5'(8 + k));
    end
`endif
    ia = 0;
    ib = 0;
    for (c = 0; c < 7; c++) begin
      bus.in_valid[1] = 1'b1;
      bus.in_valid[3] = 1'b1;
      set_tag(1, 5'(8 + ia));
      set_tag(3, 5'(16 + ib));
      @(negedge clk);
      r1 = bus.out_ready[1];
      r3 = bus.out_ready[3];
`ifdef CDB_FIXED_PRIO_EN
      exp_rdy = (c == 0) ? 2'b11 : 2'b01;
`else
      exp_rdy = (c == 0) ? 2'b11 : ((c % 2 == 1) ? 2'b10 : 2'b01);
`endif
      check("t3_ready", 64'({r3, r1}), 64'(exp_rdy));
      tick;
      if (r1) ia++;
      if (r3) ib++;
    end
    bus.in_valid = '0;
`ifdef CDB_FIXED_PRIO_EN
    check("t3_cnt1", 64'(ia), 64'(7));
    check("t3_cnt3", 64'(ib), 64'(1));
`else
    check("t3_cnt1", 64'(ia), 64'(4));
    check("t3_cnt3", 64'(ib), 64'(4));
`endif
    repeat (5) tick;
    check("t3_drained", 64'(exp_q.size()), 64'(0));

    // ---- source 0 blocked while source 1 owns the grant, then refilled ----
    do_reset;
    set_tag(0, 5'd2);
    bus.in_valid[0] = 1'b1;
    push_exp(0, 5'd2);
    tick;
    bus.in_valid = '0;
    repeat (3) tick;
`ifdef CDB_FIXED_PRIO_EN
    push_exp(0, 5'd4);
    push_exp(0, 5'd6);
    push_exp(1, 5'd5);
`else
    push_exp(1, 5'd5);
    push_exp(0, 5'd4);
    push_exp(0, 5'd6);
`endif
    set_tag(0, 5'd4);
    set_tag(1, 5'd5);
    bus.in_valid[0] = 1'b1;
    bus.in_valid[1] = 1'b1;
    @(negedge clk);
    check("t5_ready_both", 64'(bus.out_ready[1:0]), 64'(2'b11));
    tick;
    bus.in_valid[1] = 1'b0;
    set_tag(0, 5'd6);
    waited = 0;
    @(negedge clk);
    r0 = bus.out_ready[0];
`ifdef CDB_FIXED_PRIO_EN
    check("t5_blocked", 64'(r0), 64'(1));
`else
    check("t5_blocked", 64'(r0), 64'(0));
`endif
    while (!r0 && waited < 4) begin
      tick;
      waited++;
      @(negedge clk);
      r0 = bus.out_ready[0];
    end
    check("t5_refill_ready", 64'(r0), 64'(1));
    tick;
    bus.in_valid = '0;
`ifdef CDB_FIXED_PRIO_EN
    check("t5_wait", 64'(waited), 64'(0));
`else
    check("t5_wait", 64'(waited), 64'(1));
`endif
    repeat (5) tick;
    check("t5_drained", 64'(exp_q.size()), 64'(0));

    // ---- asynchronous reset with three slots full ----
    for (int i = 0; i < 3; i++) begin
      set_tag(i, 5'(20 + i));
      bus.in_valid[i] = 1'b1;
    end
    tick;
    bus.in_valid = '0;
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_reset_outputs("t6_async");
    tick;
    rst = 1'b0;
    b0 = bcast_cnt;
    repeat (5) tick;
    check("t6_no_bcast", 64'(bcast_cnt - b0), 64'(0));

    check("final_drained", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
